output_buffer_ctrl: RTL and testbench



---
 rtl/obuf_pkg.sv | 16 +
 rtl/obuf_if.sv | 25 ++
 rtl/obuf_tile_counter.sv | 17 +
 rtl/output_buffer_ctrl.sv | 59 +++++
 tb/tb_output_buffer_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/obuf_pkg.sv
// obuf_pkg: shared constants, index widths and state encoding for the output buffer controller
package obuf_pkg;
  localparam int SUB_TILES  = 4;
  localparam int UNIT_TILES = 8;
  localparam int PE_NUM     = SUB_TILES * UNIT_TILES;
  localparam int DATA_NUM   = 16;
  localparam int RD_LAT     = 1;
  localparam int PE_W       = 5;
  localparam int DATA_W     = 4;
  localparam int SUB_W      = 2;
  localparam int UNIT_W     = 3;
  localparam int CNT_W      = PE_W + DATA_W;
  localparam int VEC_BEATS  = SUB_TILES * UNIT_TILES;
  localparam int SCL_BEATS  = PE_NUM * DATA_NUM;
  typedef enum logic [2:0] {IDLE, WR_VEC, WR_SCL, DRAIN, FLUSH, DONE} obuf_state_t;
endpackage

// File: rtl/obuf_if.sv
// obuf_if: producer/consumer handshakes and buffer control bundle of the output buffer controller
interface obuf_if;
  import obuf_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic              is_scalar;
  logic              output_write_en;
  logic              output_read_en;
  logic [PE_W-1:0]   pe_idx;
  logic [DATA_W-1:0] data_idx;
  logic [SUB_W-1:0]  sub_tile_idx;
  logic [UNIT_W-1:0] unit_tile_idx;
  modport master (
    input  in_valid, out_ready,
    output in_ready, out_valid, is_scalar, output_write_en, output_read_en,
           pe_idx, data_idx, sub_tile_idx, unit_tile_idx
  );
  modport slave (
    output in_valid, out_ready,
    input  in_ready, out_valid, is_scalar, output_write_en, output_read_en,
           pe_idx, data_idx, sub_tile_idx, unit_tile_idx
  );
endinterface

// File: rtl/obuf_tile_counter.sv
// obuf_tile_counter: nested tile index counter, {sub,unit} in vector mode or {pe,data} in scalar mode
module obuf_tile_counter import obuf_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         scalar,
  output logic [W-1:0] cnt,
  output logic         last
);
  assign last = cnt == (scalar ? W'(SCL_BEATS - 1) : W'(VEC_BEATS - 1));
  always_ff @(posedge clk)
    if (!rst || clr) cnt <= '0;
    else if (inc) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/output_buffer_ctrl.sv
// output_buffer_ctrl: fills the 4-MLB output buffer from the PE array, then drains it in tile order
module output_buffer_ctrl import obuf_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  input  logic     start,
  input  logic     scalar_mode,
  input  logic     abort,
  obuf_if.master   bus,
  output logic     busy,
  output logic     done
);
  obuf_state_t state, nxt;
  logic scl, ov, wr_acc, rd_en, wr_last, rd_last;
  logic [CNT_W-1:0] wr_cnt;
  logic [SUB_W+UNIT_W-1:0] rd_cnt;
  assign bus.in_ready        = (state == WR_VEC || state == WR_SCL) && !abort;
  assign wr_acc              = bus.in_ready && bus.in_valid;
  assign rd_en               = state == DRAIN && !abort && (!ov || bus.out_ready);
  assign bus.output_write_en = wr_acc;
  assign bus.output_read_en  = rd_en;
  assign bus.out_valid       = ov;
  assign bus.is_scalar       = scl;
  assign bus.pe_idx          = scl ? wr_cnt[CNT_W-1:DATA_W] : '0;
  assign bus.data_idx        = scl ? wr_cnt[DATA_W-1:0] : '0;
  // scalar tiles address sub/unit from the PE number; otherwise the active side's tile counter
  assign {bus.sub_tile_idx, bus.unit_tile_idx} = scl ? wr_cnt[CNT_W-1:DATA_W] :
                                                 state == DRAIN ? rd_cnt : wr_cnt[SUB_W+UNIT_W-1:0];
  assign busy = state != IDLE;
  assign done = state == DONE;
  obuf_tile_counter #(.W(CNT_W)) u_wr (
    .clk(clk), .rst(rst), .clr(abort), .inc(wr_acc), .scalar(scl), .cnt(wr_cnt), .last(wr_last)
  );
  obuf_tile_counter #(.W(SUB_W+UNIT_W)) u_rd (
    .clk(clk), .rst(rst), .clr(abort), .inc(rd_en), .scalar(1'b0), .cnt(rd_cnt), .last(rd_last)
  );
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk)
    if (!rst || abort) scl <= 1'b0;
    else if (state == IDLE && start) scl <= scalar_mode;
    else if (nxt == DRAIN) scl <= 1'b0;
  // the buffer holds out[] while no read is issued, so a single valid flag covers backpressure
  always_ff @(posedge clk)
    if (!rst || abort) ov <= 1'b0;
    else ov <= rd_en || (ov && !bus.out_ready);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:           nxt = start ? (scalar_mode ? WR_SCL : WR_VEC) : IDLE;
      WR_VEC, WR_SCL: nxt = wr_acc && wr_last ? DRAIN : state;
      DRAIN:          nxt = rd_en && rd_last ? FLUSH : DRAIN;
      FLUSH:          nxt = ov && bus.out_ready ? DONE : FLUSH;
      DONE:           nxt = IDLE;
      default:        nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
endmodule

// File: tb/tb_output_buffer_ctrl.sv
// tb_output_buffer_ctrl: scoreboard bench for the output buffer controller
module tb_output_buffer_ctrl;
  import obuf_pkg::*;
  typedef struct packed {
    logic              scl;
    logic [PE_W-1:0]   pe;
    logic [DATA_W-1:0] data;
    logic [SUB_W-1:0]  sub;
    logic [UNIT_W-1:0] unit;
  } beat_t;
  logic clk = 0, rst = 0, start = 0, scalar_mode = 0, abort = 0;
  logic busy, done;
  obuf_if bus();
  output_buffer_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .scalar_mode(scalar_mode), .abort(abort),
    .bus(bus), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, wr_n = 0, rd_n = 0, hs_n = 0, dn_n = 0, dn_cyc = 0;
  int b_wr, b_rd, b_hs, b_dn, t0, n;
  logic stall_prev = 0;
  beat_t wr_q[$], rd_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return 32'({bus.in_ready, bus.out_valid, bus.is_scalar, bus.output_write_en, bus.output_read_en,
                bus.pe_idx, bus.data_idx, bus.sub_tile_idx, bus.unit_tile_idx, busy, done});
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (rst) begin
      if (bus.output_write_en) begin
        wr_n <= wr_n + 1;
        if (wr_q.size() == 0) chk("wr_extra", 32'(1), 32'(0));
        else begin
          chk("wr_idx", 32'({bus.is_scalar, bus.sub_tile_idx, bus.unit_tile_idx}),
              32'({wr_q[0].scl, wr_q[0].sub, wr_q[0].unit}));
          if (wr_q[0].scl) chk("wr_pe_data", 32'({bus.pe_idx, bus.data_idx}), 32'({wr_q[0].pe, wr_q[0].data}));
          wr_q.delete(0);
        end
      end
      if (bus.output_read_en) begin
        rd_n <= rd_n + 1;
        if (rd_q.size() == 0) chk("rd_extra", 32'(1), 32'(0));
        else begin
          chk("rd_idx", 32'({bus.is_scalar, bus.sub_tile_idx, bus.unit_tile_idx}),
              32'({rd_q[0].scl, rd_q[0].sub, rd_q[0].unit}));
          rd_q.delete(0);
        end
      end
      if (bus.out_valid && bus.out_ready) hs_n <= hs_n + 1;
      if (stall_prev) chk("ov_hold", 32'(bus.out_valid), 32'(1));
      if (bus.out_valid && !bus.out_ready) chk("rd_stalled", 32'(bus.output_read_en), 32'(0));
      stall_prev <= bus.out_valid && !bus.out_ready;
      if (done) begin
        dn_n <= dn_n + 1;
        dn_cyc <= cyc;
      end
    end else stall_prev <= 1'b0;
  task automatic push_exp(input bit scl);
    if (scl)
      for (int p = 0; p < PE_NUM; p++)
        for (int d = 0; d < DATA_NUM; d++)
          wr_q.push_back({1'b1, PE_W'(p), DATA_W'(d), SUB_W'(p / UNIT_TILES), UNIT_W'(p % UNIT_TILES)});
    for (int s = 0; s < SUB_TILES; s++)
      for (int u = 0; u < UNIT_TILES; u++) begin
        if (!scl) wr_q.push_back({1'b0, PE_W'(0), DATA_W'(0), SUB_W'(s), UNIT_W'(u)});
        rd_q.push_back({1'b0, PE_W'(0), DATA_W'(0), SUB_W'(s), UNIT_W'(u)});
      end
  endtask
  task automatic start_tile(input bit scl);
    b_wr = wr_n; b_rd = rd_n; b_hs = hs_n; b_dn = dn_n;
    scalar_mode = scl;
    start = 1;
    t0 = cyc;
    tick();
    start = 0;
    scalar_mode = 0;
  endtask
  task automatic write_phase(input bit gaps);
    int k = 0;
    while (bus.in_ready && k < 3000) begin
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    chk("wr_phase_end", 32'(bus.in_ready), 32'(0));
    if (gaps) bus.in_valid = 0;
  endtask
  task automatic drain_phase(input int stall_at, input int exp_w);
    int k = 0;
    bit stalled = 0;
    while (dn_n == b_dn && k < 1000) begin
      if (stall_at >= 0 && !stalled && hs_n - b_hs == stall_at) begin
        bus.out_ready = 0;
        repeat (5) tick();
        bus.out_ready = 1;
        stalled = 1;
      end
      tick();
      k++;
    end
    bus.in_valid = 0;
    chk("done_pulse", 32'(dn_n - b_dn), 32'(1));
    repeat (2) tick();
    chk("done_once", 32'(dn_n - b_dn), 32'(1));
    chk("wr_beats", 32'(wr_n - b_wr), 32'(exp_w));
    chk("rd_beats", 32'(rd_n - b_rd), 32'(VEC_BEATS));
    chk("handshakes", 32'(hs_n - b_hs), 32'(VEC_BEATS));
    chk("queues_empty", 32'(wr_q.size() + rd_q.size()), 32'(0));
    chk("idle_after", outs(), 32'(0));
  endtask
  initial begin
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (2) tick();
    chk("reset_outputs", outs(), 32'(0));
    rst = 1;
    tick();
    chk("idle_outputs", outs(), 32'(0));
    // vector tile, in_valid held past the terminal beat
    push_exp(0);
    start_tile(0);
    chk("busy_start", 32'(busy), 32'(1));
    write_phase(0);
    drain_phase(-1, VEC_BEATS);
    chk("latency_window", 32'(dn_cyc - t0 >= 2 * VEC_BEATS + RD_LAT + 1 && dn_cyc - t0 <= 2 * VEC_BEATS + RD_LAT + 3), 32'(1));
    // scalar tile
    push_exp(1);
    start_tile(1);
    chk("scalar_sel", 32'(bus.is_scalar), 32'(1));
    write_phase(0);
    drain_phase(-1, SCL_BEATS);
    // random producer gaps, consumer stall at drain beat 10
    push_exp(0);
    start_tile(0);
    write_phase(1);
    drain_phase(10, VEC_BEATS);
    // abort on write beat 20
    push_exp(0);
    start_tile(0);
    bus.in_valid = 1;
    n = 0;
    while (wr_n - b_wr < 20 && n < 100) begin tick(); n++; end
    abort = 1;
    tick();
    abort = 0;
    bus.in_valid = 0;
    chk("abort_idle", outs(), 32'(0));
    repeat (3) tick();
    chk("abort_no_done", 32'(dn_n - b_dn), 32'(0));
    chk("abort_beats", 32'(wr_n - b_wr), 32'(20));
    wr_q.delete();
    rd_q.delete();
    push_exp(0);
    start_tile(0);
    write_phase(0);
    drain_phase(-1, VEC_BEATS);
    // reset at drain read 7, then a start while busy must be ignored
    push_exp(0);
    start_tile(0);
    write_phase(0);
    bus.in_valid = 0;
    n = 0;
    while (rd_n - b_rd < 7 && n < 100) begin tick(); n++; end
    rst = 0;
    tick();
    chk("rst_outputs", outs(), 32'(0));
    rst = 1;
    wr_q.delete();
    rd_q.delete();
    tick();
    push_exp(0);
    start_tile(0);
    bus.in_valid = 1;
    repeat (5) tick();
    scalar_mode = 1;
    start = 1;
    tick();
    start = 0;
    scalar_mode = 0;
    chk("start_ignored", 32'(bus.is_scalar), 32'(0));
    write_phase(0);
    drain_phase(-1, VEC_BEATS);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
